// File: rtl/enc_prio_pipe_if.sv
// enc_prio_pipe_if: request-side and result-side handshake bundle for the
// registered priority encoder, including the error-reporting signals.
// master = producer/consumer side, slave = the encoder block.
interface enc_prio_pipe_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    localparam int W = $clog2(N);

    logic             in_vld;
    logic             in_rdy;
    logic [N-1:0]     in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [W-1:0]     out_idx;
    logic             out_any;
    logic             out_multi;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic             err_clr;

    modport master (
        output in_vld, in_data, out_rdy, err_clr,
        input  in_rdy, out_vld, out_idx, out_any, out_multi, err_sticky, err_cnt
    );

    modport slave (
        input  in_vld, in_data, out_rdy, err_clr,
        output in_rdy, out_vld, out_idx, out_any, out_multi, err_sticky, err_cnt
    );
endinterface

// File: rtl/enc_prio_pipe.sv
// enc_prio_pipe: registered N-to-log2(N) priority encoder with valid/ready on
// both sides, one-cycle latency and full throughput. Reports the winning
// index, an any-bit flag and a multi-hot flag, plus a sticky multi-hot error
// and a saturating multi-hot event counter.
// Optional feature: define ENC_RR_EN for round-robin priority (search starts
// one past the last granted index); otherwise the lowest set index wins.
module enc_prio_pipe #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    enc_prio_pipe_if.slave bus
);
    localparam int W = $clog2(N);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [W-1:0]     idx_q;
    logic             any_q;
    logic             multi_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic [W-1:0]     nxt_idx;
    logic             nxt_any;
    logic             nxt_multi;

    assign bus.in_rdy     = (state_q == EMPTY) || bus.out_rdy;
    assign accept         = bus.in_vld && bus.in_rdy;
    assign bus.out_vld    = (state_q == FULL);
    assign bus.out_idx    = idx_q;
    assign bus.out_any    = any_q;
    assign bus.out_multi  = multi_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = cnt_q;

    // Any-bit and multi-hot flags: clearing the lowest set bit leaves
    // something behind only when two or more bits were set.
    always_comb begin
        nxt_any   = |bus.in_data;
        nxt_multi = |(bus.in_data & (bus.in_data - 1'b1));
    end

`ifdef ENC_RR_EN
    logic [W-1:0] ptr_q;
    logic         rr_found;
    int           rr_pos;

    // Round-robin search: start at the pointer, wrap through N-1 back to 0.
    always_comb begin
        nxt_idx  = '0;
        rr_found = 1'b0;
        rr_pos   = 0;
        for (int k = 0; k < N; k++) begin
            rr_pos = int'(ptr_q) + k;
            if (rr_pos >= N) rr_pos = rr_pos - N;
            if (!rr_found && bus.in_data[rr_pos]) begin
                rr_found = 1'b1;
                nxt_idx  = W'(rr_pos);
            end
        end
    end

    // Pointer moves one past the winner on every accepted non-zero word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept && nxt_any) begin
            ptr_q <= (int'(nxt_idx) == N - 1) ? '0 : nxt_idx + W'(1);
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest set index last.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        nxt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in_data[i]) nxt_idx = W'(i);
        end
    end
`endif

    // Two-state control: EMPTY fills on accept, FULL drains on out_rdy without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (bus.out_rdy && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State register.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Result register loads only on accept, so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            any_q   <= 1'b0;
            multi_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= nxt_idx;
            any_q   <= nxt_any;
            multi_q <= nxt_multi;
        end
    end

    // Error tracking: an accepted multi-hot word beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept && nxt_multi) begin
            sticky_q <= 1'b1;
            if (bus.err_clr)      cnt_q <= CNT_W'(1);
            else if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end else if (bus.err_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end
    end
endmodule

// File: tb/tb_enc_prio_pipe.sv
// tb_enc_prio_pipe: directed scoreboard bench for enc_prio_pipe (N=8, CNT_W=2).
// The driver pushes the hand-computed result of every accepted word; a monitor
// pops and compares whenever the DUT completes an output transfer.
module tb_enc_prio_pipe;
    localparam int N     = 8;
    localparam int CNT_W = 2;
`ifdef ENC_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [2:0] idx;
        logic       any;
        logic       multi;
        logic       sticky;
        logic [1:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    enc_prio_pipe_if #(.N(N), .CNT_W(CNT_W)) bus ();

    enc_prio_pipe #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] idx, input logic any, input logic multi,
                                input logic sticky, input logic [1:0] cnt);
        exp_t e;
        e.idx = idx; e.any = any; e.multi = multi; e.sticky = sticky; e.cnt = cnt;
        return e;
    endfunction

    // Drives a word from posedge+1; pushes its expectation once in_rdy is seen.
    task automatic send(input logic [7:0] d, input exp_t e, input logic clr);
        bus.in_vld  = 1'b1;
        bus.in_data = d;
        bus.err_clr = clr;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.in_rdy === 1'b1) begin
                exp_q.push_back(e);
                @(posedge clk); #1;
                bus.in_vld  = 1'b0;
                bus.err_clr = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: word %0h never accepted, in_rdy=%0b", d, bus.in_rdy);
        bus.in_vld  = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    // Monitor: compare every completed output transfer against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_vld", 32'(bus.out_vld), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_idx",    32'(bus.out_idx),    32'(e.idx));
                    check("out_any",    32'(bus.out_any),    32'(e.any));
                    check("out_multi",  32'(bus.out_multi),  32'(e.multi));
                    check("err_sticky", 32'(bus.err_sticky), 32'(e.sticky));
                    check("err_cnt",    32'(bus.err_cnt),    32'(e.cnt));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_vld",    32'(bus.out_vld),    32'd0);
        check("rst_out_idx",    32'(bus.out_idx),    32'd0);
        check("rst_out_any",    32'(bus.out_any),    32'd0);
        check("rst_out_multi",  32'(bus.out_multi),  32'd0);
        check("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
        check("rst_err_cnt",    32'(bus.err_cnt),    32'd0);
        check("rst_in_rdy",     32'(bus.in_rdy),     32'd1);
        @(posedge clk); #1;
        bus.out_rdy = 1'b1;

        // One-hot sweep, back to back
        for (int i = 0; i < N; i++) begin
            send(8'(1 << i), mk(3'(i), 1'b1, 1'b0, 1'b0, 2'd0), 1'b0);
        end

        // Zero vector, then multi-hot 8'h28
        send(8'h00, mk(3'd0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
        send(8'h28, mk(3'd3, 1'b1, 1'b1, 1'b1, 2'd1), 1'b0);

        // Backpressure: 8'h10 held while the next word waits
        send(8'h10, mk(3'd4, 1'b1, 1'b0, 1'b1, 2'd1), 1'b0);
        bus.out_rdy = 1'b0;
        bus.in_vld  = 1'b1;
        bus.in_data = 8'h02;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_rdy",  32'(bus.in_rdy),  32'd0);
            check("bp_out_vld", 32'(bus.out_vld), 32'd1);
            check("bp_out_idx", 32'(bus.out_idx), 32'd4);
        end
        @(posedge clk); #1;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_in_rdy", 32'(bus.in_rdy), 32'd1);
        exp_q.push_back(mk(3'd1, 1'b1, 1'b0, 1'b1, 2'd1));
        @(posedge clk); #1;
        bus.in_vld = 1'b0;

        // Standalone clear
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        check("clr_err_sticky", 32'(bus.err_sticky), 32'd0);
        check("clr_err_cnt",    32'(bus.err_cnt),    32'd0);
        @(posedge clk); #1;

        // Saturation with CNT_W=2, then clear coinciding with a multi-hot accept
        send(8'h03, mk(3'd0, 1'b1, 1'b1, 1'b1, 2'd1), 1'b0);
        send(8'hC0, mk(3'd6, 1'b1, 1'b1, 1'b1, 2'd2), 1'b0);
        send(8'hFF, mk(RR ? 3'd7 : 3'd0, 1'b1, 1'b1, 1'b1, 2'd3), 1'b0);
        send(8'h18, mk(3'd3, 1'b1, 1'b1, 1'b1, 2'd3), 1'b0);
        send(8'h06, mk(3'd1, 1'b1, 1'b1, 1'b1, 2'd1), 1'b1);

        // Async reset mid-stall with out_vld=1 and err_cnt=2
        send(8'h0C, mk(3'd2, 1'b1, 1'b1, 1'b1, 2'd2), 1'b0);
        bus.out_rdy = 1'b0;
        @(negedge clk);
        check("pre_rst_out_vld", 32'(bus.out_vld), 32'd1);
        check("pre_rst_err_cnt", 32'(bus.err_cnt), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_vld",    32'(bus.out_vld),    32'd0);
        check("arst_out_idx",    32'(bus.out_idx),    32'd0);
        check("arst_out_any",    32'(bus.out_any),    32'd0);
        check("arst_out_multi",  32'(bus.out_multi),  32'd0);
        check("arst_err_sticky", 32'(bus.err_sticky), 32'd0);
        check("arst_err_cnt",    32'(bus.err_cnt),    32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        check("post_rst_in_rdy",  32'(bus.in_rdy),  32'd1);
        check("post_rst_out_vld", 32'(bus.out_vld), 32'd0);
        @(posedge clk); #1;

        // Priority on 8'h81 from a fresh pointer, then a zero word
        send(8'h81, mk(3'd0,             1'b1, 1'b1, 1'b1, 2'd1), 1'b0);
        send(8'h81, mk(RR ? 3'd7 : 3'd0, 1'b1, 1'b1, 1'b1, 2'd2), 1'b0);
        send(8'h81, mk(3'd0,             1'b1, 1'b1, 1'b1, 2'd3), 1'b0);
        send(8'h81, mk(RR ? 3'd7 : 3'd0, 1'b1, 1'b1, 1'b1, 2'd3), 1'b0);
        send(8'h00, mk(3'd0,             1'b0, 1'b0, 1'b1, 2'd3), 1'b0);
        send(8'h81, mk(3'd0,             1'b1, 1'b1, 1'b1, 2'd3), 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
